// File: rtl/async_operator_buf_pkg.sv
// ============================================================================
// async_op_pkg : operator encoding and fold/truncate evaluation helpers
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package async_op_pkg;

   // Widest supported operand and channel count; narrower nodes zero-extend.
   localparam int MAX_W  = 64;
   localparam int MAX_IN = 4;

   typedef logic [MAX_W-1:0]             word_t;
   typedef logic [MAX_IN-1:0][MAX_W-1:0] opnd_vec_t;

   typedef enum logic [3:0] {
      OP_REG, OP_IN, OP_OUT, OP_ADD, OP_SUB, OP_MUL, OP_ADDI,
      OP_SUBI, OP_MULI, OP_MIN, OP_MAX, OP_AND, OP_OR, OP_XOR
   } op_e;

   function automatic op_e op_decode(input string s);
      op_e r;
      r = OP_REG;
      if (s == "in")   r = OP_IN;
      if (s == "out")  r = OP_OUT;
      if (s == "add")  r = OP_ADD;
      if (s == "sub")  r = OP_SUB;
      if (s == "mul")  r = OP_MUL;
      if (s == "addi") r = OP_ADDI;
      if (s == "subi") r = OP_SUBI;
      if (s == "muli") r = OP_MULI;
      if (s == "min")  r = OP_MIN;
      if (s == "max")  r = OP_MAX;
      if (s == "and")  r = OP_AND;
      if (s == "or")   r = OP_OR;
      if (s == "xor")  r = OP_XOR;
      return r;
   endfunction

   // Left fold over the first n operands, then truncation to width bits.
   function automatic word_t op_eval(input op_e op, input opnd_vec_t v, input int n,
                                     input word_t imm, input int width);
      word_t acc;
      acc = v[0];
      case (op)
         OP_ADDI: acc = v[0] + imm;
         OP_SUBI: acc = v[0] - imm;
         OP_MULI: acc = v[0] * imm;
         default: begin
            for (int i = 1; i < MAX_IN; i++) begin
               if (i < n) begin
                  case (op)
                     OP_ADD:  acc = acc + v[i];
                     OP_SUB:  acc = acc - v[i];
                     OP_MUL:  acc = acc * v[i];
                     OP_MIN:  acc = (v[i] < acc) ? v[i] : acc;
                     OP_MAX:  acc = (v[i] > acc) ? v[i] : acc;
                     OP_AND:  acc = acc & v[i];
                     OP_OR:   acc = acc | v[i];
                     OP_XOR:  acc = acc ^ v[i];
                     default: acc = acc;
                  endcase
               end
            end
         end
      endcase
      return acc & ~({MAX_W{1'b1}} << width);
   endfunction

endpackage

`default_nettype wire

// File: rtl/async_operator_buf_if.sv
// ============================================================================
// async_operator_buf_if : producer/consumer handshake bundle of the operator
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface async_operator_buf_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int INPUT_SIZE  = 1,
   parameter int OUTPUT_SIZE = 1,
   parameter int DEPTH       = 2
);
   localparam int LEVEL_W = $clog2(DEPTH + 1);

   logic [INPUT_SIZE-1:0]            req_l;
   logic [INPUT_SIZE-1:0]            ack_l;
   logic [DATA_WIDTH*INPUT_SIZE-1:0] din;
   logic [OUTPUT_SIZE-1:0]           req_r;
   logic [OUTPUT_SIZE-1:0]           ack_r;
   logic [DATA_WIDTH-1:0]            dout;
   logic [LEVEL_W-1:0]               level;
   logic [31:0]                      fire_count;

   modport master (
      input  req_l, ack_r, dout, level, fire_count,
      output ack_l, din, req_r
   );

   modport slave (
      output req_l, ack_r, dout, level, fire_count,
      input  ack_l, din, req_r
   );
endinterface

`default_nettype wire

// File: rtl/async_operator_buf_fifo.sv
// ============================================================================
// async_op_fifo : DEPTH-entry result queue, register storage, head on rdata
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module async_op_fifo #(
   parameter int DEPTH      = 2,
   parameter int DATA_WIDTH = 32
) (
   input  wire logic                         clk,
   input  wire logic                         rst,
   input  wire logic                         i_push,
   input  wire logic                         i_pop,
   input  wire logic [DATA_WIDTH-1:0]        i_wdata,
   output logic      [DATA_WIDTH-1:0]        o_rdata,
   output logic                              o_full,
   output logic                              o_empty,
   output logic      [$clog2(DEPTH+1)-1:0]   o_level
);
   localparam int c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_LEVEL_W = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_LEVEL_W-1:0]  r_level;
   logic                  w_push_ok;
   logic                  w_pop_ok;

   function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
   endfunction

   assign o_full    = (r_level == c_LEVEL_W'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (w_pop_ok) r_rd_ptr <= next_ptr(r_rd_ptr);
         if (w_push_ok && !w_pop_ok)      r_level <= r_level + c_LEVEL_W'(1);
         else if (!w_push_ok && w_pop_ok) r_level <= r_level - c_LEVEL_W'(1);
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/async_operator_buf.sv
// ============================================================================
// async_operator_buf : buffered N-input operator with independent fan-out acks
// Optional macro ASYNC_OP_STATS_EN enables the fire_count statistics counter.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module async_operator_buf
   import async_op_pkg::*;
#(
   parameter int    DATA_WIDTH  = 32,
   parameter string OP          = "reg",
   parameter int    IMMEDIATE   = 0,
   parameter int    INPUT_SIZE  = 1,
   parameter int    OUTPUT_SIZE = 1,
   parameter int    DEPTH       = 2
) (
   input wire logic            clk,
   input wire logic            rst,
   async_operator_buf_if.slave bus
);
   localparam op_e c_OP_SEL  = op_decode(OP);
   localparam int  c_LEVEL_W = $clog2(DEPTH + 1);

   localparam logic [1:0] S_WAIT = 2'd0;
   localparam logic [1:0] S_ACK  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [INPUT_SIZE-1:0]  w_has;
   logic [OUTPUT_SIZE-1:0] w_served;
   opnd_vec_t              w_opnd_ext;
   logic [DATA_WIDTH-1:0]  w_result;
   logic [DATA_WIDTH-1:0]  w_rdata;
   logic [c_LEVEL_W-1:0]   w_level;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_fire;
   logic                   w_pop;

   // Full is the registered occupancy: a pop in the same cycle does not free a slot.
   assign w_fire = (&w_has) && !w_full;
   assign w_pop  = &w_served;

   generate
      for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_in
         logic                  r_has;
         logic                  r_req;
         logic [DATA_WIDTH-1:0] r_opnd;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_has  <= 1'b0;
               r_req  <= 1'b0;
               r_opnd <= '0;
            end else if (!r_has) begin
               if (bus.ack_l[gi]) begin
                  r_opnd <= bus.din[gi*DATA_WIDTH +: DATA_WIDTH];
                  r_has  <= 1'b1;
                  r_req  <= 1'b0;
               end else begin
                  r_req  <= 1'b1;
               end
            end else if (w_fire) begin
               r_has <= 1'b0;
            end
         end

         assign w_has[gi]      = r_has;
         assign bus.req_l[gi]  = r_req;
         assign w_opnd_ext[gi] = word_t'(r_opnd);
      end

      for (genvar gz = INPUT_SIZE; gz < MAX_IN; gz++) begin : g_pad
         assign w_opnd_ext[gz] = '0;
      end
   endgenerate

   assign w_result = DATA_WIDTH'(op_eval(c_OP_SEL, w_opnd_ext, INPUT_SIZE,
                                         word_t'(IMMEDIATE), DATA_WIDTH));

   async_op_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_fire),
      .i_pop   (w_pop),
      .i_wdata (w_result),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign bus.dout  = w_rdata;
   assign bus.level = w_level;

   // Each consumer walks WAIT -> ACK (one-cycle pulse) -> DONE until the shared pop.
   generate
      for (genvar gj = 0; gj < OUTPUT_SIZE; gj++) begin : g_out
         logic [1:0] r_state;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_state <= S_WAIT;
            end else begin
               case (r_state)
                  S_WAIT:  if (!w_empty && bus.req_r[gj]) r_state <= S_ACK;
                  S_ACK:   r_state <= w_pop ? S_WAIT : S_DONE;
                  S_DONE:  if (w_pop) r_state <= S_WAIT;
                  default: r_state <= S_WAIT;
               endcase
            end
         end

         assign w_served[gj]  = (r_state != S_WAIT);
         assign bus.ack_r[gj] = (r_state == S_ACK);
      end
   endgenerate

`ifdef ASYNC_OP_STATS_EN
   logic [31:0] r_fire_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_fire_count <= '0;
      else if (w_fire) r_fire_count <= r_fire_count + 32'd1;
   end

   assign bus.fire_count = r_fire_count;
`else
   assign bus.fire_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_operator_buf.sv
// ============================================================================
// tb_async_operator_buf : directed vectors and corner sequences for the operator
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_operator_buf;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

`ifdef ASYNC_OP_STATS_EN
   localparam bit c_STATS = 1'b1;
`else
   localparam bit c_STATS = 1'b0;
`endif

   async_operator_buf_if #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(3), .DEPTH(3)) ifA ();
   async_operator_buf_if #(.DATA_WIDTH(8),  .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(2)) ifB ();
   async_operator_buf_if #(.DATA_WIDTH(16), .INPUT_SIZE(3), .OUTPUT_SIZE(2), .DEPTH(2)) ifC ();
   async_operator_buf_if #(.DATA_WIDTH(8),  .INPUT_SIZE(4), .OUTPUT_SIZE(1), .DEPTH(2)) ifD ();

   async_operator_buf #(.DATA_WIDTH(32), .OP("add"), .IMMEDIATE(0), .INPUT_SIZE(2),
                        .OUTPUT_SIZE(3), .DEPTH(3))
      dutA (.clk(clk), .rst(rst), .bus(ifA));
   async_operator_buf #(.DATA_WIDTH(8), .OP("subi"), .IMMEDIATE(2), .INPUT_SIZE(1),
                        .OUTPUT_SIZE(1), .DEPTH(2))
      dutB (.clk(clk), .rst(rst), .bus(ifB));
   async_operator_buf #(.DATA_WIDTH(16), .OP("sub"), .IMMEDIATE(0), .INPUT_SIZE(3),
                        .OUTPUT_SIZE(2), .DEPTH(2))
      dutC (.clk(clk), .rst(rst), .bus(ifC));
   async_operator_buf #(.DATA_WIDTH(8), .OP("max"), .IMMEDIATE(0), .INPUT_SIZE(4),
                        .OUTPUT_SIZE(1), .DEPTH(2))
      dutD (.clk(clk), .rst(rst), .bus(ifD));

   typedef struct {
      int          dut;
      logic [31:0] a, b, c, d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [18];
   int   n_checks  = 0;
   int   n_errors  = 0;
   int   exp_fires = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out waiting for handshake", nm);
   endtask

   function automatic logic req_all(input int d);
      case (d)
         0:       return &ifA.req_l;
         1:       return &ifB.req_l;
         2:       return &ifC.req_l;
         default: return &ifD.req_l;
      endcase
   endfunction

   function automatic logic ack_any(input int d);
      case (d)
         0:       return |ifA.ack_r;
         1:       return |ifB.ack_r;
         2:       return |ifC.ack_r;
         default: return |ifD.ack_r;
      endcase
   endfunction

   function automatic logic ack_all(input int d);
      case (d)
         0:       return &ifA.ack_r;
         1:       return &ifB.ack_r;
         2:       return &ifC.ack_r;
         default: return &ifD.ack_r;
      endcase
   endfunction

   function automatic logic [31:0] dout_of(input int d);
      case (d)
         0:       return ifA.dout;
         1:       return {24'd0, ifB.dout};
         2:       return {16'd0, ifC.dout};
         default: return {24'd0, ifD.dout};
      endcase
   endfunction

   task automatic drive(input vec_t v, input logic en);
      case (v.dut)
         0: begin ifA.din = {v.b, v.a}; ifA.ack_l = {2{en}}; end
         1: begin ifB.din = v.a[7:0]; ifB.ack_l = en; end
         2: begin ifC.din = {v.c[15:0], v.b[15:0], v.a[15:0]}; ifC.ack_l = {3{en}}; end
         default: begin
            ifD.din = {v.d[7:0], v.c[7:0], v.b[7:0], v.a[7:0]};
            ifD.ack_l = {4{en}};
         end
      endcase
   endtask

   task automatic apply(input vec_t v, input int idx);
      int t;
      t = 0;
      while (!req_all(v.dut) && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) timeout($sformatf("vec%0d_req_l", idx));
      drive(v, 1'b1);
      @(negedge clk);
      drive(v, 1'b0);
      if (v.dut == 0) exp_fires++;
      t = 0;
      while (!ack_any(v.dut) && t < 10) begin @(negedge clk); t++; end
      if (t >= 10) begin
         timeout($sformatf("vec%0d_ack_r", idx));
      end else begin
         chk($sformatf("vec%0d_dut%0d_dout", idx, v.dut), 64'(dout_of(v.dut)), 64'(v.exp));
         chk($sformatf("vec%0d_dut%0d_ack_all", idx, v.dut), 64'(ack_all(v.dut)), 64'd1);
      end
      @(negedge clk);
   endtask

   task automatic feedA(input logic [31:0] a, input logic [31:0] b, input string nm);
      int t;
      t = 0;
      while (!(&ifA.req_l) && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) timeout(nm);
      ifA.din   = {b, a};
      ifA.ack_l = 2'b11;
      @(negedge clk);
      ifA.ack_l = 2'b00;
      exp_fires++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t, idx, c0, c1, c2;
      logic fed5, seen_req;

      vecs[0]  = '{0, 32'd3,          32'd5,          0, 0, 32'd8};
      vecs[1]  = '{0, 32'hFFFF_FFFF,  32'd1,          0, 0, 32'd0};
      vecs[2]  = '{0, 32'h8000_0000,  32'h8000_0000,  0, 0, 32'd0};
      vecs[3]  = '{0, 32'h1234,       32'd1,          0, 0, 32'h1235};
      vecs[4]  = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0, 32'hFFFF_FFFE};
      vecs[5]  = '{1, 32'd1,   0, 0, 0, 32'hFF};
      vecs[6]  = '{1, 32'd0,   0, 0, 0, 32'hFE};
      vecs[7]  = '{1, 32'd2,   0, 0, 0, 32'h00};
      vecs[8]  = '{1, 32'hC8,  0, 0, 0, 32'hC6};
      vecs[9]  = '{1, 32'hFF,  0, 0, 0, 32'hFD};
      vecs[10] = '{2, 32'd10,  32'd3,      32'd2,  0, 32'd5};
      vecs[11] = '{2, 32'd0,   32'd1,      32'd1,  0, 32'hFFFE};
      vecs[12] = '{2, 32'd100, 32'd50,     32'd50, 0, 32'd0};
      vecs[13] = '{2, 32'd1,   32'hFFFF,   32'd0,  0, 32'd2};
      vecs[14] = '{3, 32'd1,   32'hC8, 32'd3, 32'd4, 32'hC8};
      vecs[15] = '{3, 32'h80,  32'h7F, 32'd0, 32'd1, 32'h80};
      vecs[16] = '{3, 32'd5,   32'd5,  32'd5, 32'd5, 32'd5};
      vecs[17] = '{3, 32'd0,   32'd0,  32'd0, 32'd0, 32'd0};

      ifA.ack_l = '0; ifA.din = '0; ifA.req_r = 3'b111;
      ifB.ack_l = '0; ifB.din = '0; ifB.req_r = 1'b1;
      ifC.ack_l = '0; ifC.din = '0; ifC.req_r = 2'b11;
      ifD.ack_l = '0; ifD.din = '0; ifD.req_r = 1'b1;

      // Reset values, then req_l rises one cycle after release
      repeat (2) @(negedge clk);
      chk("rst_req_l", 64'(ifA.req_l), 64'd0);
      chk("rst_ack_r", 64'(ifA.ack_r), 64'd0);
      chk("rst_dout",  64'(ifA.dout),  64'd0);
      chk("rst_level", 64'(ifA.level), 64'd0);
      chk("rst_fire_count", 64'(ifA.fire_count), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("release_req_l", 64'(ifA.req_l), 64'd3);

      // Latency: capture k, fire k+1, ack k+2, pop k+3
      ifA.din = {32'd5, 32'd3}; ifA.ack_l = 2'b11;
      @(negedge clk);
      ifA.ack_l = 2'b00; exp_fires++;
      chk("lat_capture_req_l", 64'(ifA.req_l), 64'd0);
      chk("lat_capture_level", 64'(ifA.level), 64'd0);
      @(negedge clk);
      chk("lat_fire_level", 64'(ifA.level), 64'd1);
      chk("lat_fire_ack_r", 64'(ifA.ack_r), 64'd0);
      @(negedge clk);
      chk("lat_ack_r", 64'(ifA.ack_r), 64'd7);
      chk("lat_dout",  64'(ifA.dout),  64'd8);
      chk("lat_req_l", 64'(ifA.req_l), 64'd3);
      @(negedge clk);
      chk("lat_pop_ack_r", 64'(ifA.ack_r), 64'd0);
      chk("lat_pop_level", 64'(ifA.level), 64'd0);

      for (int i = 0; i < 18; i++) apply(vecs[i], i);

      // Slow consumer 1: others ack once, pop waits for consumer 1
      ifA.req_r = 3'b101;
      feedA(32'd3, 32'd4, "slow_req_l");
      c0 = 0; c1 = 0; c2 = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (ifA.ack_r != 3'b000) chk("slow_dout", 64'(ifA.dout), 64'd7);
         c0 += int'(ifA.ack_r[0]);
         c1 += int'(ifA.ack_r[1]);
         c2 += int'(ifA.ack_r[2]);
      end
      chk("slow_acks_c0", 64'(c0), 64'd1);
      chk("slow_acks_c1", 64'(c1), 64'd0);
      chk("slow_acks_c2", 64'(c2), 64'd1);
      chk("slow_level_held", 64'(ifA.level), 64'd1);
      ifA.req_r = 3'b111;
      @(negedge clk);
      chk("slow_c1_ack_r", 64'(ifA.ack_r), 64'd2);
      chk("slow_c1_dout",  64'(ifA.dout),  64'd7);
      @(negedge clk);
      chk("slow_pop_level", 64'(ifA.level), 64'd0);
      chk("slow_pop_ack_r", 64'(ifA.ack_r), 64'd0);

      // Saturation at DEPTH=3 with consumers idle
      ifA.req_r = 3'b000;
      for (int k = 0; k < 4; k++) feedA(32'(k), 32'd0, $sformatf("sat_req_l_%0d", k));
      repeat (2) @(negedge clk);
      chk("sat_level", 64'(ifA.level), 64'd3);
      // Duplicate ack while operands are held must be ignored
      ifA.din = {32'd0, 32'd99}; ifA.ack_l = 2'b11;
      @(negedge clk);
      ifA.ack_l = 2'b00;
      seen_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (ifA.req_l != 2'b00) seen_req = 1'b1;
      end
      chk("sat_req_l_low", 64'(seen_req), 64'd0);
      chk("sat_level_hold", 64'(ifA.level), 64'd3);
      chk("sat_fire_count", 64'(ifA.fire_count), c_STATS ? 64'(exp_fires - 1) : 64'd0);

      ifA.req_r = 3'b111;
      idx = 0; fed5 = 1'b0; t = 0;
      while (idx < 5 && t < 60) begin
         @(negedge clk);
         t++;
         ifA.ack_l = 2'b00;
         if (ifA.ack_r != 3'b000) begin
            chk($sformatf("drain_%0d_dout", idx), 64'(ifA.dout), 64'(idx));
            chk($sformatf("drain_%0d_ack_r", idx), 64'(ifA.ack_r), 64'd7);
            idx++;
         end
         if (!fed5 && (&ifA.req_l)) begin
            ifA.din = {32'd0, 32'd4}; ifA.ack_l = 2'b11;
            fed5 = 1'b1;
            exp_fires++;
         end
      end
      ifA.ack_l = 2'b00;
      if (idx < 5) timeout("drain");
      @(negedge clk);
      chk("drain_level", 64'(ifA.level), 64'd0);
      chk("drain_fire_count", 64'(ifA.fire_count), c_STATS ? 64'(exp_fires) : 64'd0);

      // Mid-stream reset with two queued results and one held operand
      ifA.req_r = 3'b000;
      feedA(32'd10, 32'd1, "rst_feed0");
      feedA(32'd20, 32'd2, "rst_feed1");
      repeat (3) @(negedge clk);
      chk("pre_rst_level", 64'(ifA.level), 64'd2);
      chk("pre_rst_dout",  64'(ifA.dout),  64'd11);
      chk("pre_rst_fire_count", 64'(ifA.fire_count), c_STATS ? 64'(exp_fires) : 64'd0);
      ifA.din = {32'd0, 32'd50}; ifA.ack_l = 2'b01;
      @(negedge clk);
      ifA.ack_l = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_ack_r", 64'(ifA.ack_r), 64'd0);
      chk("mid_rst_dout",  64'(ifA.dout),  64'd0);
      chk("mid_rst_level", 64'(ifA.level), 64'd0);
      chk("mid_rst_req_l", 64'(ifA.req_l), 64'd0);
      chk("mid_rst_fire_count", 64'(ifA.fire_count), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      exp_fires = 0;
      @(negedge clk);
      chk("post_rst_req_l", 64'(ifA.req_l), 64'd3);
      ifA.req_r = 3'b111;
      ifA.din = {32'd2, 32'd0}; ifA.ack_l = 2'b10;
      @(negedge clk);
      ifA.ack_l = 2'b00;
      repeat (4) @(negedge clk);
      chk("post_rst_no_fire", 64'(ifA.level), 64'd0);
      ifA.din = {32'd0, 32'd7}; ifA.ack_l = 2'b01;
      @(negedge clk);
      ifA.ack_l = 2'b00;
      exp_fires++;
      t = 0;
      while (!(|ifA.ack_r) && t < 10) begin @(negedge clk); t++; end
      if (t >= 10) timeout("post_rst_ack_r");
      else chk("post_rst_dout", 64'(ifA.dout), 64'd9);
      chk("post_rst_fire_count", 64'(ifA.fire_count), c_STATS ? 64'(exp_fires) : 64'd0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
